// File: rtl/ssg_frame_gen.sv
//------------------------------------------------------------------------------
// Module : ssg_frame_gen
// Queued SIGNAL header + PRBS payload serial bit generator (valid/ready out).
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ssg_frame_gen #(
  parameter int TYPE_W    = 4,
  parameter int LEN_W     = 12,
  parameter int TAIL_W    = 6,
  parameter int SEED_W    = 7,
  parameter int REQ_DEPTH = 4,
  parameter int GAP_CYC   = 2
) (
  input  logic              ssg_clk,
  input  logic              ssg_rst_n,
  input  logic [TYPE_W-1:0] req_type,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [SEED_W-1:0] req_seed,
  input  logic              req_vld,
  output logic              req_rdy,
  output logic              ssg_do,
  output logic              ssg_do_vld,
  input  logic              ssg_do_rdy,
  output logic              ssg_do_hdr,
  output logic              ssg_do_sof,
  output logic              ssg_do_eof,
  output logic [SEED_W-1:0] ssg_do_init,
  output logic              busy,
  output logic [15:0]       frame_cnt
);

  localparam int c_HDR_W = TYPE_W + 1 + LEN_W + 1 + TAIL_W;
  localparam int c_CNT_W = LEN_W + 3;
  localparam int c_PTR_W = $clog2(REQ_DEPTH);
  localparam int c_GAP_W = $clog2(GAP_CYC + 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_PLD  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic [TYPE_W-1:0]  r_fifo_type [REQ_DEPTH];
  logic [LEN_W-1:0]   r_fifo_len  [REQ_DEPTH];
  logic [SEED_W-1:0]  r_fifo_seed [REQ_DEPTH];
  logic [c_PTR_W-1:0] r_wptr, r_rptr;
  logic [c_PTR_W:0]   r_count, w_count_nxt;
  logic               r_req_rdy, w_push, w_pop;

  logic [LEN_W-1:0]   r_len;
  logic [SEED_W-1:0]  r_prbs, w_prbs_nxt;
  logic               w_prbs_bit;
  logic [c_HDR_W-2:0] r_hdr_sr;
  logic [c_CNT_W-1:0] r_cnt, w_pld_bits;
  logic [c_GAP_W-1:0] r_gap;
  logic               r_do, r_do_vld, r_do_hdr, r_do_sof, r_do_eof;
  logic [SEED_W-1:0]  r_do_init;
  logic [15:0]        r_frame_cnt;

  logic [TYPE_W-1:0]  w_head_type;
  logic [LEN_W-1:0]   w_head_len;
  logic [SEED_W-1:0]  w_head_seed;
  logic [c_HDR_W-1:0] w_hdr_word;
  logic               w_xfer, w_hdr_last, w_pld_last, w_gap_done;

  // Request FIFO; a full FIFO refuses pushes even when a pop frees a slot this cycle
  assign w_push = req_vld && r_req_rdy;
  assign w_pop  = (r_state == S_IDLE) && (r_count != '0);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)
      w_count_nxt = r_count + (c_PTR_W+1)'(1);
    else if (!w_push && w_pop)
      w_count_nxt = r_count - (c_PTR_W+1)'(1);
  end

  always_ff @(posedge ssg_clk) begin
    if (w_push) begin
      r_fifo_type[r_wptr] <= req_type;
      r_fifo_len[r_wptr]  <= req_len;
      r_fifo_seed[r_wptr] <= req_seed;
    end
  end

  always_ff @(posedge ssg_clk or negedge ssg_rst_n) begin
    if (!ssg_rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_req_rdy <= 1'b0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + c_PTR_W'(1);
      if (w_pop)
        r_rptr <= r_rptr + c_PTR_W'(1);
      r_count   <= w_count_nxt;
      r_req_rdy <= (w_count_nxt != (c_PTR_W+1)'(REQ_DEPTH));
    end
  end

  assign w_head_type = r_fifo_type[r_rptr];
  assign w_head_len  = r_fifo_len[r_rptr];
  assign w_head_seed = (r_fifo_seed[r_rptr] == '0) ? '1 : r_fifo_seed[r_rptr];
  // Bit 0 goes out first: type, reserved 0, length, even parity, tail zeros
  assign w_hdr_word  = {{TAIL_W{1'b0}}, ^{w_head_len, w_head_type}, w_head_len, 1'b0, w_head_type};

  assign w_prbs_bit = r_prbs[SEED_W-1] ^ r_prbs[SEED_W-4];
  assign w_prbs_nxt = {r_prbs[SEED_W-2:0], w_prbs_bit};

  assign w_xfer     = r_do_vld && ssg_do_rdy;
  assign w_pld_bits = {r_len, 3'b000};
  assign w_hdr_last = (r_cnt == c_CNT_W'(c_HDR_W - 1));
  assign w_pld_last = (r_cnt == w_pld_bits - c_CNT_W'(1));
  assign w_gap_done = (r_gap == c_GAP_W'(GAP_CYC - 1));

  always_ff @(posedge ssg_clk or negedge ssg_rst_n) begin
    if (!ssg_rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_pop) w_state_nxt = S_HDR;
      S_HDR: begin
        if (w_xfer && w_hdr_last) begin
          if (r_len != '0)
            w_state_nxt = S_PLD;
          else
            w_state_nxt = (GAP_CYC == 0) ? S_IDLE : S_GAP;
        end
      end
      S_PLD: if (w_xfer && w_pld_last) w_state_nxt = (GAP_CYC == 0) ? S_IDLE : S_GAP;
      S_GAP: if (w_gap_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output/datapath registers only move on a pop or an accepted bit, so a stall holds them
  always_ff @(posedge ssg_clk or negedge ssg_rst_n) begin
    if (!ssg_rst_n) begin
      r_len       <= '0;
      r_prbs      <= '0;
      r_hdr_sr    <= '0;
      r_cnt       <= '0;
      r_gap       <= '0;
      r_do        <= 1'b0;
      r_do_vld    <= 1'b0;
      r_do_hdr    <= 1'b0;
      r_do_sof    <= 1'b0;
      r_do_eof    <= 1'b0;
      r_do_init   <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_gap <= (r_state == S_GAP) ? r_gap + c_GAP_W'(1) : '0;
      if (w_xfer && r_do_eof)
        r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_pop) begin
        r_len     <= w_head_len;
        r_prbs    <= w_head_seed;
        r_do_init <= w_head_seed;
        r_hdr_sr  <= w_hdr_word[c_HDR_W-1:1];
        r_do      <= w_hdr_word[0];
        r_cnt     <= '0;
        r_do_vld  <= 1'b1;
        r_do_hdr  <= 1'b1;
        r_do_sof  <= 1'b1;
        r_do_eof  <= 1'b0;
      end else if (w_xfer) begin
        r_do_sof <= 1'b0;
        if ((r_state == S_HDR && w_hdr_last && r_len == '0) ||
            (r_state == S_PLD && w_pld_last)) begin
          r_do      <= 1'b0;
          r_do_vld  <= 1'b0;
          r_do_hdr  <= 1'b0;
          r_do_eof  <= 1'b0;
          r_do_init <= '0;
        end else if (r_state == S_HDR && w_hdr_last) begin
          r_do     <= w_prbs_bit;
          r_prbs   <= w_prbs_nxt;
          r_cnt    <= '0;
          r_do_hdr <= 1'b0;
          r_do_eof <= 1'b0;
        end else if (r_state == S_HDR) begin
          r_do     <= r_hdr_sr[0];
          r_hdr_sr <= r_hdr_sr >> 1;
          r_cnt    <= r_cnt + c_CNT_W'(1);
          r_do_eof <= (r_len == '0) && (r_cnt == c_CNT_W'(c_HDR_W - 2));
        end else begin
          r_do     <= w_prbs_bit;
          r_prbs   <= w_prbs_nxt;
          r_cnt    <= r_cnt + c_CNT_W'(1);
          r_do_eof <= (r_cnt + c_CNT_W'(2) == w_pld_bits);
        end
      end
    end
  end

  assign req_rdy     = r_req_rdy;
  assign ssg_do      = r_do;
  assign ssg_do_vld  = r_do_vld;
  assign ssg_do_hdr  = r_do_hdr;
  assign ssg_do_sof  = r_do_sof;
  assign ssg_do_eof  = r_do_eof;
  assign ssg_do_init = r_do_init;
  assign busy        = (r_state != S_IDLE) || (r_count != '0);
  assign frame_cnt   = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ssg_frame_gen.sv
//------------------------------------------------------------------------------
// Module : tb_ssg_frame_gen
// Self-checking bench for ssg_frame_gen: vector table plus multi-cycle sequences.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ssg_frame_gen;

  localparam int TYPE_W  = 4;
  localparam int LEN_W   = 12;
  localparam int TAIL_W  = 6;
  localparam int SEED_W  = 7;
  localparam int GAP_CYC = 2;
  localparam int HDR_W   = TYPE_W + 1 + LEN_W + 1 + TAIL_W;

  logic              ssg_clk = 1'b0;
  logic              ssg_rst_n = 1'b0;
  logic [TYPE_W-1:0] req_type = '0;
  logic [LEN_W-1:0]  req_len = '0;
  logic [SEED_W-1:0] req_seed = '0;
  logic              req_vld = 1'b0;
  logic              req_rdy;
  logic              ssg_do, ssg_do_vld, ssg_do_hdr, ssg_do_sof, ssg_do_eof;
  logic              ssg_do_rdy = 1'b1;
  logic [SEED_W-1:0] ssg_do_init;
  logic              busy;
  logic [15:0]       frame_cnt;

  ssg_frame_gen dut (
    .ssg_clk(ssg_clk), .ssg_rst_n(ssg_rst_n),
    .req_type(req_type), .req_len(req_len), .req_seed(req_seed),
    .req_vld(req_vld), .req_rdy(req_rdy),
    .ssg_do(ssg_do), .ssg_do_vld(ssg_do_vld), .ssg_do_rdy(ssg_do_rdy),
    .ssg_do_hdr(ssg_do_hdr), .ssg_do_sof(ssg_do_sof), .ssg_do_eof(ssg_do_eof),
    .ssg_do_init(ssg_do_init), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 ssg_clk = ~ssg_clk;

  typedef struct {
    logic [TYPE_W-1:0] t;
    logic [LEN_W-1:0]  l;
    logic [SEED_W-1:0] sd;
    logic [HDR_W-1:0]  hdr;   // bit i = i-th header bit on the wire
    logic [7:0]        pl8;   // bit i = i-th payload bit
    logic [SEED_W-1:0] init;
    int                nbits;
  } vec_t;

  vec_t vecs [5];

  int n_chk = 0, n_fail = 0;
  int exp_frames = 0;

  logic              mon_bit [$];
  logic              mon_hdr [$];
  logic              mon_sof [$];
  logic              mon_eof [$];
  logic [SEED_W-1:0] mon_init [$];
  int                mon_cyc [$];
  int                mon_eofs = 0;
  int                cyc = 0;
  logic              stall_chk = 1'b0;
  logic              prev_stall = 1'b0;
  logic [SEED_W+4:0] prev_out = '0;
  logic              exp_q [$];
  logic              ref_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Records every accepted bit; also checks outputs hold across a stall
  always @(negedge ssg_clk) begin
    cyc++;
    if (stall_chk && prev_stall)
      check("stall_hold", 64'({ssg_do_init, ssg_do, ssg_do_vld, ssg_do_hdr, ssg_do_sof, ssg_do_eof}),
            64'(prev_out));
    prev_stall = ssg_do_vld && !ssg_do_rdy;
    prev_out   = {ssg_do_init, ssg_do, ssg_do_vld, ssg_do_hdr, ssg_do_sof, ssg_do_eof};
    if (ssg_do_vld && ssg_do_rdy) begin
      mon_bit.push_back(ssg_do);
      mon_hdr.push_back(ssg_do_hdr);
      mon_sof.push_back(ssg_do_sof);
      mon_eof.push_back(ssg_do_eof);
      mon_init.push_back(ssg_do_init);
      mon_cyc.push_back(cyc);
      if (ssg_do_eof) mon_eofs++;
    end
  end

  task automatic mon_clear();
    mon_bit.delete(); mon_hdr.delete(); mon_sof.delete();
    mon_eof.delete(); mon_init.delete(); mon_cyc.delete();
    mon_eofs = 0;
  endtask

  task automatic build_exp(input logic [TYPE_W-1:0] t, input logic [LEN_W-1:0] l,
                           input logic [SEED_W-1:0] sd);
    logic [SEED_W-1:0] s;
    logic b;
    exp_q.delete();
    for (int i = 0; i < TYPE_W; i++) exp_q.push_back(t[i]);
    exp_q.push_back(1'b0);
    for (int i = 0; i < LEN_W; i++) exp_q.push_back(l[i]);
    exp_q.push_back(^{t, l});
    for (int i = 0; i < TAIL_W; i++) exp_q.push_back(1'b0);
    s = (sd == '0) ? 7'h7F : sd;
    for (int i = 0; i < int'(l) * 8; i++) begin
      b = s[6] ^ s[3];
      exp_q.push_back(b);
      s = {s[5:0], b};
    end
  endtask

  task automatic push_req(input logic [TYPE_W-1:0] t, input logic [LEN_W-1:0] l,
                          input logic [SEED_W-1:0] sd);
    @(posedge ssg_clk); #1;
    req_type = t; req_len = l; req_seed = sd; req_vld = 1'b1;
    @(posedge ssg_clk); #1;
    req_vld = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int c = 0;
    while (busy !== 1'b0 && c < 200) begin @(posedge ssg_clk); #1; c++; end
    if (busy !== 1'b0) begin
      n_chk++; n_fail++;
      $display("FAIL %s: busy still high after %0d cycles", name, c);
    end
  endtask

  task automatic wait_eofs(input int n, input int bound, input string name);
    int c = 0;
    while (mon_eofs < n && c < bound) begin @(negedge ssg_clk); #1; c++; end
    if (mon_eofs < n) begin
      n_chk++; n_fail++;
      $display("FAIL %s: saw %0d eof, expected %0d within %0d cycles", name, mon_eofs, n, bound);
    end
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    int ferr, merr, n;
    logic [HDR_W-1:0] h;
    logic [7:0] p;
    wait_idle($sformatf("v%0d_idle", idx));
    mon_clear();
    ssg_do_rdy = 1'b1;
    push_req(v.t, v.l, v.sd);
    check($sformatf("v%0d_vld_before_sof", idx), 64'(ssg_do_vld), 64'(0));
    @(posedge ssg_clk); #1;
    check($sformatf("v%0d_sof_latency", idx), 64'({ssg_do_vld, ssg_do_sof, ssg_do_hdr}), 64'(3'b111));
    wait_eofs(1, v.nbits + 50, $sformatf("v%0d_eof", idx));
    @(posedge ssg_clk); #1;
    exp_frames++;
    check($sformatf("v%0d_frame_cnt", idx), 64'(frame_cnt), 64'(exp_frames));
    n = mon_bit.size();
    check($sformatf("v%0d_nbits", idx), 64'(n), 64'(v.nbits));
    h = '0;
    for (int i = 0; i < HDR_W; i++) h[i] = (i < n) ? mon_bit[i] : 1'bx;
    check($sformatf("v%0d_header", idx), 64'(h), 64'(v.hdr));
    if (v.l != '0) begin
      p = '0;
      for (int i = 0; i < 8; i++) p[i] = (HDR_W + i < n) ? mon_bit[HDR_W + i] : 1'bx;
      check($sformatf("v%0d_payload8", idx), 64'(p), 64'(v.pl8));
    end
    if (n > 0) check($sformatf("v%0d_init", idx), 64'(mon_init[0]), 64'(v.init));
    ferr = 0;
    for (int i = 0; i < n; i++) begin
      if (mon_sof[i]  !== (i == 0))     ferr++;
      if (mon_hdr[i]  !== (i < HDR_W))  ferr++;
      if (mon_eof[i]  !== (i == n - 1)) ferr++;
      if (mon_init[i] !== v.init)       ferr++;
    end
    check($sformatf("v%0d_flag_errors", idx), 64'(ferr), 64'(0));
    build_exp(v.t, v.l, v.sd);
    merr = 0;
    for (int i = 0; i < n && i < exp_q.size(); i++)
      if (mon_bit[i] !== exp_q[i]) merr++;
    check($sformatf("v%0d_bit_errors", idx), 64'(merr), 64'(0));
  endtask

  initial begin
    int c, acc, nf, merr;
    int sofs [$];
    logic [TYPE_W-1:0] tp;

    vecs[0] = '{4'hB, 12'd100, 7'h7F, 24'h000C8B, 8'h70, 7'h7F, 824};
    vecs[1] = '{4'h1, 12'd0,   7'h7F, 24'h020001, 8'h00, 7'h7F, 24};
    vecs[2] = '{4'hB, 12'd2,   7'h00, 24'h00004B, 8'h70, 7'h7F, 40};
    vecs[3] = '{4'h2, 12'd1,   7'h01, 24'h000022, 8'hC8, 7'h01, 32};
    vecs[4] = '{4'h7, 12'd3,   7'h7F, 24'h020067, 8'h70, 7'h7F, 48};

    // Reset state
    #12;
    check("rst_outputs", 64'({req_rdy, ssg_do, ssg_do_vld, ssg_do_hdr, ssg_do_sof, ssg_do_eof,
                               ssg_do_init, busy, frame_cnt}), 64'(0));
    #1 ssg_rst_n = 1'b1;
    @(posedge ssg_clk); #1;
    check("rdy_after_release", 64'(req_rdy), 64'(1));

    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i], i);
      if (i == 4) ref_q = mon_bit;
    end

    // Back-pressure: same frame as vecs[4] under random ready
    wait_idle("bp_idle");
    mon_clear();
    stall_chk = 1'b1;
    push_req(4'h7, 12'd3, 7'h7F);
    c = 0;
    while (mon_eofs < 1 && c < 2000) begin
      @(posedge ssg_clk); #1;
      ssg_do_rdy = 1'($urandom_range(0, 1));
      c++;
    end
    ssg_do_rdy = 1'b1;
    stall_chk = 1'b0;
    if (mon_eofs < 1) begin
      n_chk++; n_fail++;
      $display("FAIL bp_eof: no eof within %0d cycles", c);
    end
    exp_frames++;
    check("bp_frame_cnt", 64'(frame_cnt), 64'(exp_frames));
    check("bp_nbits", 64'(mon_bit.size()), 64'(ref_q.size()));
    merr = 0;
    for (int i = 0; i < mon_bit.size() && i < ref_q.size(); i++)
      if (mon_bit[i] !== ref_q[i]) merr++;
    check("bp_bit_errors", 64'(merr), 64'(0));

    // FIFO fill: one frame already in flight (stalled), then 4 more fit and the 5th is refused
    wait_idle("fifo_idle");
    mon_clear();
    ssg_do_rdy = 1'b0;
    push_req(4'h8, 12'd0, 7'h11);
    @(posedge ssg_clk); #1;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      if (req_rdy) acc++;
      req_type = TYPE_W'(9 + i); req_len = '0; req_seed = 7'h22; req_vld = 1'b1;
      @(posedge ssg_clk); #1;
    end
    req_vld = 1'b0;
    check("fifo_accepts", 64'(acc), 64'(4));
    check("fifo_full_rdy", 64'(req_rdy), 64'(0));
    ssg_do_rdy = 1'b1;
    wait_eofs(5, 400, "fifo_drain");
    @(posedge ssg_clk); #1;
    exp_frames += 5;
    check("fifo_frame_cnt", 64'(frame_cnt), 64'(exp_frames));
    sofs.delete();
    for (int i = 0; i < mon_sof.size(); i++) if (mon_sof[i]) sofs.push_back(i);
    nf = sofs.size();
    check("fifo_nframes", 64'(nf), 64'(5));
    for (int f = 0; f < nf && f < 5; f++) begin
      for (int b = 0; b < TYPE_W; b++) tp[b] = (sofs[f] + b < mon_bit.size()) ? mon_bit[sofs[f] + b] : 1'bx;
      check($sformatf("fifo_order%0d", f), 64'(tp), 64'(8 + f));
      // negedge samples from eof to next sof: eof edge, then GAP_CYC+1 cycles to sof
      if (f > 0)
        check($sformatf("fifo_gap%0d", f), 64'(mon_cyc[sofs[f]] - mon_cyc[sofs[f] - 1]), 64'(GAP_CYC + 2));
    end

    // Reset in the middle of the payload (after payload bit 10 is taken)
    wait_idle("rstmid_idle");
    mon_clear();
    push_req(4'h3, 12'd100, 7'h7F);
    c = 0;
    while (mon_bit.size() < HDR_W + 10 && c < 100) begin @(negedge ssg_clk); #1; c++; end
    check("rstmid_reached", 64'(mon_bit.size()), 64'(HDR_W + 10));
    ssg_rst_n = 1'b0;
    #1;
    check("rstmid_outputs", 64'({ssg_do_vld, ssg_do_sof, ssg_do_eof, ssg_do_hdr, busy, req_rdy}), 64'(0));
    check("rstmid_frame_cnt", 64'(frame_cnt), 64'(0));
    exp_frames = 0;
    @(posedge ssg_clk); #1;
    ssg_rst_n = 1'b1;
    @(posedge ssg_clk); #1;
    check("rstmid_rdy", 64'(req_rdy), 64'(1));
    check("rstmid_busy", 64'(busy), 64'(0));
    run_frame(vecs[3], 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

`default_nettype wire
